// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: round-robin arbiter giving two requesters single-transaction access to a register file,
// with writes from requester A blocked at and above RO_BASE.
module reg_access_arbiter #(
    parameter logic [7:0] RO_BASE = 8'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [7:0] a_index,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    output logic       a_err,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [7:0] b_index,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic [7:0] b_rdata,
    output logic       ram_write,
    output logic       ram_read,
    output logic [7:0] ram_index,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;
    state_t     state_q, state_d;
    logic       we_q, owner_q, prio_b_q, err_q;
    logic [7:0] index_q, wdata_q, a_rdata_q, b_rdata_q;
    logic       grant, win, prot;
    // win is 1 when B takes the grant; prio_b_q says who wins a tie
    always_comb begin
        grant     = a_req | b_req;
        win       = (a_req & b_req) ? prio_b_q : b_req;
        prot      = we_q & ~owner_q & (index_q >= RO_BASE);
        state_d   = (state_q == IDLE)  ? (grant ? ISSUE : IDLE) :
                    (state_q == ISSUE) ? (we_q ? ACK : RDWAIT) :
                    (state_q == RDWAIT) ? ACK : IDLE;
        ram_write = (state_q == ISSUE) & we_q & ~prot;
        ram_read  = (state_q == ISSUE) & ~we_q;
        a_ack     = (state_q == ACK) & ~owner_q;
        b_ack     = (state_q == ACK) & owner_q;
        a_err     = a_ack & err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            owner_q   <= 1'b0;
            prio_b_q  <= 1'b0;
            err_q     <= 1'b0;
            index_q   <= 8'h00;
            wdata_q   <= 8'h00;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant) begin
                we_q     <= win ? b_we : a_we;
                index_q  <= win ? b_index : a_index;
                wdata_q  <= win ? b_wdata : a_wdata;
                owner_q  <= win;
                prio_b_q <= ~win;
            end
            if (state_q == ISSUE) err_q <= prot;
            if (state_q == ACK) err_q <= 1'b0;
            if (state_q == RDWAIT && !owner_q) a_rdata_q <= ram_rdata;
            if (state_q == RDWAIT && owner_q) b_rdata_q <= ram_rdata;
        end
    end
    assign ram_index = index_q;
    assign ram_wdata = wdata_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign owner     = owner_q;
endmodule
